// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: sequencer that streams N_TERMS sample/coefficient pairs from
// two synchronous-read memories into an attached MAC and returns the
// accumulated Q7.8 dot product on a valid/ready output.
module mac_dot_ctrl #(
  parameter int N_TERMS = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_data,
  output logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_data,
  output logic [DATA_W-1:0] mac_x1,
  output logic [DATA_W-1:0] mac_x2,
  output logic              mac_load,
  input  logic [DATA_W-1:0] mac_out,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    ACC     = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_TERMS - 1);
  localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr;

  // State, term counter and captured-result registers; reset clears all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic and MAC/memory drive; operands are zero outside ACC so
  // the MAC holds its accumulator while idle or waiting on the consumer.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    result_d = result_q;
    valid_d  = valid_q;
    addr     = '0;
    mac_x1   = '0;
    mac_x2   = '0;
    mac_load = 1'b0;
    busy     = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        k_d  = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        // Address 0 is presented here so its data arrives in ACC k=0.
        k_d     = '0;
        state_d = ACC;
      end
      ACC: begin
        mac_x1   = x_data;
        mac_x2   = c_data;
        mac_load = (k_q == '0);
        // Prefetch the next term; the wrap after the last term is unused.
        addr     = k_q + K_ONE;
        k_d      = k_q + K_ONE;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        result_d = mac_out;
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x_addr       = addr;
  assign c_addr       = addr;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed bench for mac_dot_ctrl with a behavioural Q7.8 MAC and two
// synchronous-read memories attached.
module tb_mac_dot_ctrl;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] x_addr, c_addr;
  logic [DW-1:0] x_data, c_data;
  logic [DW-1:0] mac_x1, mac_x2, mac_out, result;
  logic          mac_load, result_valid;
  logic          result_ready = 1'b0;

  logic [DW-1:0] xmem [N];
  logic [DW-1:0] cmem [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_dot_ctrl #(.N_TERMS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .x_addr(x_addr), .x_data(x_data), .c_addr(c_addr), .c_data(c_data),
    .mac_x1(mac_x1), .mac_x2(mac_x2), .mac_load(mac_load), .mac_out(mac_out),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  // Synchronous-read memories
  always_ff @(posedge clk) begin
    x_data <= xmem[x_addr];
    c_data <= cmem[c_addr];
  end

  // Responder MAC: Q7.8 product plus prior sum, wrapping, shares reset
  logic signed [31:0] prod;
  assign prod = $signed(mac_x1) * $signed(mac_x2);
  always_ff @(posedge clk) begin
    if (reset) mac_out <= '0;
    else       mac_out <= (mac_load ? 16'h0000 : mac_out) + prod[23:8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] xv, input logic [DW-1:0] c_even,
                      input logic [DW-1:0] c_odd);
    for (int i = 0; i < N; i++) begin
      xmem[i] = xv;
      cmem[i] = (i % 2 == 0) ? c_even : c_odd;
    end
  endtask

  // Start an operation and wait (bounded) for result_valid; checks latency,
  // busy throughout and the load strobe appearing only in ACC k=0.
  task automatic run_op(input string name, input logic [DW-1:0] exp_res);
    int cyc;
    int loads;
    int load_at;
    bit busy_ok;
    cyc = 0; loads = 0; load_at = -1; busy_ok = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!result_valid && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (mac_load) begin loads++; load_at = cyc; end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== N + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, N + 2);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp_res);
    end
    checks++;
    if (!busy_ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got low during operation expected 1", name);
    end
    checks++;
    if (loads !== 1 || load_at !== 1) begin
      errors++;
      $display("FAIL %s load: got %0d pulses at cycle %0d expected 1 at cycle 1",
               name, loads, load_at);
    end
  endtask

  task automatic handshake(input string name);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b busy=%b expected 0 0",
               name, result_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, result_valid, mac_load, x_addr, c_addr, mac_x1, mac_x2, result, mac_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b valid=%b load=%b xa=%h ca=%h x1=%h x2=%h res=%h mac=%h expected all 0",
               busy, result_valid, mac_load, x_addr, c_addr, mac_x1, mac_x2, result, mac_out);
    end
  endtask

  task automatic test_ones();
    fill(16'h0100, 16'h0100, 16'h0100);
    run_op("ones", 16'h2000);
    handshake("ones");
  endtask

  task automatic test_alternating();
    fill(16'h0100, 16'h0100, 16'hFF00);
    run_op("alt", 16'h0000);
    handshake("alt");
  endtask

  task automatic test_wrap();
    fill(16'h7F00, 16'h0100, 16'h0100);
    run_op("wrap", 16'hE000);
    handshake("wrap");
  endtask

  task automatic test_backpressure();
    bit stable;
    fill(16'h0100, 16'h0100, 16'h0100);
    run_op("bp", 16'h2000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      if (result_valid !== 1'b1 || result !== 16'h2000 || busy !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: got valid=%b res=%h busy=%b expected 1 2000 1",
               result_valid, result, busy);
    end
    // start coincident with the handshake must not be taken
    start = 1'b1;
    handshake("bp");
    start = 1'b0;
    checks++;
    if (result !== 16'h2000) begin
      errors++;
      $display("FAIL bp_result_kept: got %h expected 2000", result);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_start_not_queued: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_acc();
    fill(16'h0100, 16'h0100, 16'h0100);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();  // now in ACC k=10
    checks++;
    if (x_addr !== 5'd11 || mac_load !== 1'b0) begin
      errors++;
      $display("FAIL mid_acc_position: got xa=%h load=%b expected 0b 0", x_addr, mac_load);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, result_valid, mac_load, x_addr, c_addr, mac_x1, mac_x2, result, mac_out} !== '0) begin
      errors++;
      $display("FAIL mid_acc_reset: got busy=%b valid=%b load=%b xa=%h ca=%h x1=%h x2=%h res=%h mac=%h expected all 0",
               busy, result_valid, mac_load, x_addr, c_addr, mac_x1, mac_x2, result, mac_out);
    end
    run_op("after_reset", 16'h2000);
    handshake("after_reset");
  endtask

  task automatic test_back_to_back();
    fill(16'h0100, 16'h0100, 16'h0100);
    run_op("b2b_first", 16'h2000);
    handshake("b2b_first");
    fill(16'h0100, 16'h0080, 16'h0080);
    run_op("b2b_second", 16'h1000);
    handshake("b2b_second");
  endtask

  initial begin
    fill(16'h0000, 16'h0000, 16'h0000);
    test_reset();
    test_ones();
    test_alternating();
    test_wrap();
    test_backpressure();
    test_reset();
    test_ones();
    test_reset_mid_acc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
